// File: rtl/hexdump_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hexdump_pkg: formatter states, ASCII constants, nibble encoder       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package hexdump_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HI   = 3'd1,
    S_LO   = 3'd2,
    S_SEP  = 3'd3,
    S_CR   = 3'd4,
    S_LF   = 3'd5
  } state_t;

  localparam logic [7:0] c_SPACE = 8'h20;
  localparam logic [7:0] c_CR    = 8'h0D;
  localparam logic [7:0] c_LF    = 8'h0A;
  localparam logic [7:0] c_ZERO  = 8'h30;
  localparam logic [7:0] c_A     = 8'h41;

  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    if (nib < 4'd10) return c_ZERO + {4'h0, nib};
    else             return c_A + {4'h0, nib} - 8'd10;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hexdump_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hexdump_fifo: first-word-fall-through character FIFO                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hexdump_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int c_AW = $clog2(DEPTH);
  localparam logic [c_AW:0] c_FULL = (c_AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Push looks at the pre-pop full flag: a full FIFO never accepts, even when popping.
  assign w_push   = push && (r_count != c_FULL);
  assign w_pop    = pop && (r_count != '0);
  assign full     = (r_count == c_FULL);
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign pop_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/hexdump_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hexdump_bridge: binary byte stream to ASCII hex text lines           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hexdump_bridge
  import hexdump_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int BPL   = 16,
  parameter int CRLF  = 1,
  parameter int LOSSY = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_vld,
  input  logic        in_last,
  input  logic [7:0]  in_data,
  output logic        in_rdy,
  output logic        out_vld,
  output logic [7:0]  out_data,
  input  logic        out_rdy,
  output logic [15:0] drop_cnt,
  output logic        busy
);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("hexdump_bridge: DEPTH must be a power of two >= 4");
  end
  if (BPL < 1 || BPL > 256) begin : g_chk_bpl
    $error("hexdump_bridge: BPL must be in 1..256");
  end
  if (CRLF != 0 && CRLF != 1) begin : g_chk_crlf
    $error("hexdump_bridge: CRLF must be 0 or 1");
  end
  if (LOSSY != 0 && LOSSY != 1) begin : g_chk_lossy
    $error("hexdump_bridge: LOSSY must be 0 or 1");
  end

  localparam logic [7:0] c_TERM_FIRST = (CRLF != 0) ? c_CR : c_LF;
  localparam state_t     c_TERM_STATE = (CRLF != 0) ? S_CR : S_LF;

  state_t                 r_state;
  logic [7:0]             r_byte;
  logic                   r_last;
  logic                   r_pending_last;
  logic [7:0]             r_line_cnt;
  logic                   w_push;
  logic [7:0]             w_push_data;
  logic                   w_full;
  logic                   w_empty;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_drop;
  logic                   w_drop_last;
  logic                   w_term_req;
  logic                   w_line_full;
  logic                   w_line_end;

  assign in_rdy      = (LOSSY != 0) ? 1'b1 : (r_state == S_IDLE);
  assign w_drop      = (LOSSY != 0) && in_vld && (r_state != S_IDLE);
  assign w_drop_last = w_drop && in_last;
  assign w_term_req  = r_last || r_pending_last || w_drop_last;
  assign w_line_full = (r_line_cnt == 8'(BPL - 1));
  assign w_push      = (r_state != S_IDLE) && !w_full;
  // A frame end seen while the separator is still unsent turns it into the terminator.
  assign w_line_end  = w_push && ((r_state == S_LF) ||
                                  ((r_state == S_SEP) && w_term_req && (CRLF == 0)));
  assign out_vld     = !w_empty;
  assign busy        = (r_state != S_IDLE) || (w_count != '0);

  always_comb begin
    w_push_data = c_SPACE;
    case (r_state)
      S_HI:    w_push_data = nib2ascii(r_byte[7:4]);
      S_LO:    w_push_data = nib2ascii(r_byte[3:0]);
      S_SEP:   w_push_data = w_term_req ? c_TERM_FIRST : c_SPACE;
      S_CR:    w_push_data = c_CR;
      S_LF:    w_push_data = c_LF;
      default: w_push_data = c_SPACE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= S_IDLE;
      r_byte         <= '0;
      r_last         <= 1'b0;
      r_pending_last <= 1'b0;
      r_line_cnt     <= '0;
    end else begin
      if (w_line_end) begin
        r_line_cnt     <= '0;
        r_pending_last <= w_drop_last;
      end else if (w_drop_last) begin
        r_pending_last <= 1'b1;
      end
      case (r_state)
        S_IDLE: if (in_vld) begin
          r_byte  <= in_data;
          r_last  <= in_last;
          r_state <= S_HI;
        end
        S_HI:  if (w_push) r_state <= S_LO;
        S_LO:  if (w_push) begin
          r_line_cnt <= r_line_cnt + 8'd1;
          r_state    <= (w_term_req || w_line_full) ? c_TERM_STATE : S_SEP;
        end
        S_SEP: if (w_push) r_state <= (w_term_req && CRLF != 0) ? S_LF : S_IDLE;
        S_CR:  if (w_push) r_state <= S_LF;
        S_LF:  if (w_push) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  if (LOSSY != 0) begin : g_lossy
    logic [15:0] r_drop_cnt;
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                               r_drop_cnt <= '0;
      else if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
    assign drop_cnt = r_drop_cnt;
  end else begin : g_lossless
    assign drop_cnt = '0;
  end

  hexdump_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (out_rdy),
    .pop_data  (out_data),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_hexdump_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hexdump_bridge: directed tests over five parameter sets           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_hexdump_bridge;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [4:0]  in_vld = '0;
  logic [4:0]  in_last = '0;
  logic [7:0]  in_data [5];
  logic [4:0]  in_rdy;
  logic [4:0]  out_vld;
  logic [7:0]  out_data [5];
  logic [4:0]  out_rdy = '0;
  logic [15:0] drop_cnt [5];
  logic [4:0]  busy;
  string       cap [5];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  // 0: defaults, 1: BPL=4, 2: DEPTH=4, 3: LOSSY=1, 4: CRLF=0 BPL=2
  hexdump_bridge u_dut0 (.clk(clk), .resetn(resetn), .in_vld(in_vld[0]), .in_last(in_last[0]),
    .in_data(in_data[0]), .in_rdy(in_rdy[0]), .out_vld(out_vld[0]), .out_data(out_data[0]),
    .out_rdy(out_rdy[0]), .drop_cnt(drop_cnt[0]), .busy(busy[0]));
  hexdump_bridge #(.BPL(4)) u_dut1 (.clk(clk), .resetn(resetn), .in_vld(in_vld[1]),
    .in_last(in_last[1]), .in_data(in_data[1]), .in_rdy(in_rdy[1]), .out_vld(out_vld[1]),
    .out_data(out_data[1]), .out_rdy(out_rdy[1]), .drop_cnt(drop_cnt[1]), .busy(busy[1]));
  hexdump_bridge #(.DEPTH(4)) u_dut2 (.clk(clk), .resetn(resetn), .in_vld(in_vld[2]),
    .in_last(in_last[2]), .in_data(in_data[2]), .in_rdy(in_rdy[2]), .out_vld(out_vld[2]),
    .out_data(out_data[2]), .out_rdy(out_rdy[2]), .drop_cnt(drop_cnt[2]), .busy(busy[2]));
  hexdump_bridge #(.LOSSY(1)) u_dut3 (.clk(clk), .resetn(resetn), .in_vld(in_vld[3]),
    .in_last(in_last[3]), .in_data(in_data[3]), .in_rdy(in_rdy[3]), .out_vld(out_vld[3]),
    .out_data(out_data[3]), .out_rdy(out_rdy[3]), .drop_cnt(drop_cnt[3]), .busy(busy[3]));
  hexdump_bridge #(.CRLF(0), .BPL(2)) u_dut4 (.clk(clk), .resetn(resetn), .in_vld(in_vld[4]),
    .in_last(in_last[4]), .in_data(in_data[4]), .in_rdy(in_rdy[4]), .out_vld(out_vld[4]),
    .out_data(out_data[4]), .out_rdy(out_rdy[4]), .drop_cnt(drop_cnt[4]), .busy(busy[4]));

  always @(negedge clk) begin
    for (int i = 0; i < 5; i++)
      if (resetn && out_vld[i] && out_rdy[i]) cap[i] = $sformatf("%s%c", cap[i], out_data[i]);
  end

  function automatic string vis(input string s);
    string r = "";
    for (int k = 0; k < s.len(); k++) begin
      if (s[k] == 8'h0D)      r = {r, "\\r"};
      else if (s[k] == 8'h0A) r = {r, "\\n"};
      else                    r = {r, s.substr(k, k)};
    end
    return r;
  endfunction

  function automatic string tail(input int i, input int base);
    return cap[i].substr(base, cap[i].len() - 1);
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int i, input logic [7:0] d, input logic l);
    bit ok = 1'b0;
    in_vld[i] = 1'b1; in_data[i] = d; in_last[i] = l;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (in_rdy[i]) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL send_timeout inst=%0d data=%h in_rdy never 1", i, d); end
    @(posedge clk); #1;
    in_vld[i] = 1'b0; in_last[i] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      total += 4;
      if (out_vld[i] !== 1'b0) begin bad++; $display("FAIL reset_out_vld inst=%0d got=%b exp=0", i, out_vld[i]); end
      if (busy[i] !== 1'b0) begin bad++; $display("FAIL reset_busy inst=%0d got=%b exp=0", i, busy[i]); end
      if (in_rdy[i] !== 1'b1) begin bad++; $display("FAIL reset_in_rdy inst=%0d got=%b exp=1", i, in_rdy[i]); end
      if (drop_cnt[i] !== 16'h0) begin bad++; $display("FAIL reset_drop_cnt inst=%0d got=%h exp=0000", i, drop_cnt[i]); end
    end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    out_rdy[0] = 1'b1;
    in_vld[0] = 1'b1; in_data[0] = 8'h3A; in_last[0] = 1'b1;
    @(negedge clk);
    total++;
    if (in_rdy[0] !== 1'b1) begin bad++; $display("FAIL single_in_rdy got=%b exp=1", in_rdy[0]); end
    @(posedge clk); #1;
    in_vld[0] = 1'b0; in_last[0] = 1'b0;
    @(negedge clk);
    total++;
    if (out_vld[0] !== 1'b0) begin bad++; $display("FAIL single_latency_early got=%b exp=0", out_vld[0]); end
    @(negedge clk);
    total += 2;
    if (out_vld[0] !== 1'b1) begin bad++; $display("FAIL single_latency got=%b exp=1", out_vld[0]); end
    if (out_data[0] !== 8'h33) begin bad++; $display("FAIL single_first_char got=%h exp=33", out_data[0]); end
    wait_cyc(10);
    total += 2;
    if (cap[0] != "3A\r\n") begin bad++; $display("FAIL single_text got='%s' exp='3A\\r\\n'", vis(cap[0])); end
    if (busy[0] !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b exp=0", busy[0]); end
  endtask

  task automatic test_line_wrap();
    out_rdy[1] = 1'b1;
    for (int b = 0; b < 6; b++) send(1, 8'(b), b == 5);
    wait_cyc(20);
    total += 2;
    if (cap[1] != "00 01 02 03\r\n04 05\r\n")
      begin bad++; $display("FAIL line_wrap_text got='%s' exp='00 01 02 03\\r\\n04 05\\r\\n'", vis(cap[1])); end
    if (cap[1].len() != 20) begin bad++; $display("FAIL line_wrap_len got=%0d exp=20", cap[1].len()); end
  endtask

  task automatic test_backpressure();
    out_rdy[2] = 1'b0;
    in_vld[2] = 1'b1; in_data[2] = 8'hFF; in_last[2] = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    total += 5;
    if (in_rdy[2] !== 1'b0) begin bad++; $display("FAIL bp_in_rdy got=%b exp=0", in_rdy[2]); end
    if (out_vld[2] !== 1'b1) begin bad++; $display("FAIL bp_out_vld got=%b exp=1", out_vld[2]); end
    if (out_data[2] !== 8'h46) begin bad++; $display("FAIL bp_head got=%h exp=46", out_data[2]); end
    if (busy[2] !== 1'b1) begin bad++; $display("FAIL bp_busy got=%b exp=1", busy[2]); end
    if (cap[2].len() != 0) begin bad++; $display("FAIL bp_no_output got=%0d exp=0", cap[2].len()); end
    @(posedge clk); #1;
    in_vld[2] = 1'b0;
    out_rdy[2] = 1'b1;
    wait_cyc(20);
    total++;
    if (cap[2] != "FF FF ") begin bad++; $display("FAIL bp_text got='%s' exp='FF FF '", vis(cap[2])); end
  endtask

  task automatic test_lossy();
    out_rdy[3] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_vld[3] = 1'b1; in_data[3] = 8'h10 + 8'(k); in_last[3] = (k == 7);
      @(negedge clk);
      if (k == 2) begin
        total++;
        if (in_rdy[3] !== 1'b1) begin bad++; $display("FAIL lossy_in_rdy got=%b exp=1", in_rdy[3]); end
      end
      @(posedge clk); #1;
    end
    in_vld[3] = 1'b0; in_last[3] = 1'b0;
    wait_cyc(20);
    total += 2;
    if (drop_cnt[3] !== 16'd6) begin bad++; $display("FAIL lossy_drop_cnt got=%0d exp=6", drop_cnt[3]); end
    if (cap[3] != "10 14\r\n") begin bad++; $display("FAIL lossy_text got='%s' exp='10 14\\r\\n'", vis(cap[3])); end
  endtask

  task automatic test_crlf0();
    out_rdy[4] = 1'b1;
    send(4, 8'hAB, 1'b0);
    send(4, 8'hCD, 1'b0);
    send(4, 8'hEF, 1'b1);
    wait_cyc(20);
    total++;
    if (cap[4] != "AB CD\nEF\n") begin bad++; $display("FAIL crlf0_text got='%s' exp='AB CD\\nEF\\n'", vis(cap[4])); end
  endtask

  task automatic test_reset_mid();
    int base;
    base = cap[0].len();
    out_rdy[0] = 1'b0;
    send(0, 8'h12, 1'b0);
    send(0, 8'h34, 1'b0);
    @(posedge clk); #1;
    total += 2;
    if (out_vld[0] !== 1'b1) begin bad++; $display("FAIL rst_mid_pre_vld got=%b exp=1", out_vld[0]); end
    if (busy[0] !== 1'b1) begin bad++; $display("FAIL rst_mid_pre_busy got=%b exp=1", busy[0]); end
    #1 resetn = 1'b0;
    #1;
    total += 3;
    if (out_vld[0] !== 1'b0) begin bad++; $display("FAIL rst_mid_out_vld got=%b exp=0", out_vld[0]); end
    if (busy[0] !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy[0]); end
    if (in_rdy[0] !== 1'b1) begin bad++; $display("FAIL rst_mid_in_rdy got=%b exp=1", in_rdy[0]); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    out_rdy[0] = 1'b1;
    send(0, 8'h01, 1'b1);
    wait_cyc(10);
    total++;
    if (tail(0, base) != "01\r\n") begin bad++; $display("FAIL rst_mid_text got='%s' exp='01\\r\\n'", vis(tail(0, base))); end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      in_data[i] = 8'h00;
      cap[i] = "";
    end
    test_reset();
    test_single();
    test_line_wrap();
    test_backpressure();
    test_lossy();
    test_crlf0();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
